// File: rtl/layer_sched.sv
// Layer sequencer and DRAM port arbiter.
// Walks a programmed list of engine steps one at a time: enables the engine named by the
// current step, waits for its done, then advances. The single DRAM port is routed to the
// granted engine only, and a per-step watchdog flags an engine that never finishes.
module layer_sched #(
    parameter int unsigned    NUM_ENG    = 4,
    parameter int unsigned    MAX_STEPS  = 8,
    parameter int unsigned    DATA_WIDTH = 32,
    parameter int unsigned    ADDR_WIDTH = 18,
    parameter int unsigned    TO_W       = 20,
    parameter logic [TO_W-1:0] TIMEOUT   = 20'hFFFFF,
    localparam int unsigned   ENG_IDW    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1,
    localparam int unsigned   STEP_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          start,
    input  logic [STEP_W-1:0]             cfg_num_steps,
    input  logic [ENG_IDW*MAX_STEPS-1:0]  cfg_seq,
    output logic [NUM_ENG-1:0]            eng_enable,
    input  logic [NUM_ENG-1:0]            eng_done,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out,
    input  logic [NUM_ENG-1:0]            eng_en_rd,
    input  logic [NUM_ENG-1:0]            eng_en_wr,
    output logic [NUM_ENG-1:0]            eng_dram_valid,
    input  logic                          dram_valid,
    output logic [ADDR_WIDTH-1:0]         dram_addr_in,
    output logic [ADDR_WIDTH-1:0]         dram_addr_out,
    output logic [DATA_WIDTH-1:0]         dram_data_wr,
    output logic                          dram_en_rd,
    output logic                          dram_en_wr,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [STEP_W-1:0]             cur_step
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StRun,
        StDrain,
        StFin,
        StErr
    } state_e;

    state_e                         state_q, state_d;
    logic [ENG_IDW-1:0]             grant_q, grant_d;
    logic [TO_W-1:0]                wd_q, wd_d;
    logic [STEP_W-1:0]              step_q, step_d;
    logic [STEP_W-1:0]              n_q, n_d;
    logic [ENG_IDW*MAX_STEPS-1:0]   seq_q, seq_d;
    logic                           err_q, err_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [NUM_ENG-1:0]             enable_q, enable_d;

    logic [ENG_IDW-1:0]             step_id;
    logic [2**ENG_IDW-1:0]          id_ok;
    logic [NUM_ENG-1:0]             grant_oh;
    logic                           grant_done;
    logic                           run;
    logic                           sel_rd;
    logic                           sel_wr;

    // Engine id of the current step, and which ids name a real engine.
    always_comb begin
        step_id = '0;
        for (int k = 0; k < int'(MAX_STEPS); k++) begin
            if (step_q == STEP_W'(k)) begin
                step_id = seq_q[k*ENG_IDW +: ENG_IDW];
            end
        end
        for (int i = 0; i < 2**ENG_IDW; i++) begin
            id_ok[i] = (i < int'(NUM_ENG));
        end
    end

    // One-hot view of the grant; done is only taken from the granted engine.
    always_comb begin
        for (int i = 0; i < int'(NUM_ENG); i++) begin
            grant_oh[i] = (grant_q == ENG_IDW'(i));
        end
        grant_done = |(grant_oh & eng_done);
    end

    // Next-state logic for the sequencer and its registered outputs.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wd_d    = wd_q;
        step_d  = step_q;
        n_d     = n_q;
        seq_d   = seq_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StErr: begin
                if (start) begin
                    seq_d   = cfg_seq;
                    n_d     = (cfg_num_steps > STEP_W'(MAX_STEPS)) ? STEP_W'(MAX_STEPS)
                                                                   : cfg_num_steps;
                    err_d   = 1'b0;
                    step_d  = '0;
                    state_d = (n_d == '0) ? StFin : StLaunch;
                end
            end
            StLaunch: begin
                grant_d = step_id;
                wd_d    = '0;
                // An id with no engine behind it is skipped rather than run.
                state_d = id_ok[step_id] ? StRun : StDrain;
            end
            StRun: begin
                wd_d = wd_q + TO_W'(1);
                // A done arriving on the timeout cycle still counts as success.
                if (grant_done) begin
                    state_d = StDrain;
                end else if (wd_d == TIMEOUT) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end
            end
            StDrain: begin
                if (step_q == n_q - STEP_W'(1)) begin
                    state_d = StFin;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = StLaunch;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d   = (state_d == StLaunch) || (state_d == StRun) ||
                   (state_d == StDrain)  || (state_d == StFin);
        done_d   = (state_d == StFin);
        enable_d = '0;
        if (state_d == StRun) begin
            for (int i = 0; i < int'(NUM_ENG); i++) begin
                enable_d[i] = (grant_d == ENG_IDW'(i));
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            wd_q     <= '0;
            step_q   <= '0;
            n_q      <= '0;
            seq_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            enable_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            wd_q     <= wd_d;
            step_q   <= step_d;
            n_q      <= n_d;
            seq_q    <= seq_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            enable_q <= enable_d;
        end
    end

    // DRAM port mux: data/address follow the grant, enables only pass while running.
    always_comb begin
        run           = (state_q == StRun);
        dram_addr_in  = '0;
        dram_addr_out = '0;
        dram_data_wr  = '0;
        sel_rd        = 1'b0;
        sel_wr        = 1'b0;
        for (int i = 0; i < int'(NUM_ENG); i++) begin
            if (grant_oh[i]) begin
                dram_addr_in  = eng_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                dram_addr_out = eng_addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
                dram_data_wr  = eng_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rd        = eng_en_rd[i];
                sel_wr        = eng_en_wr[i];
            end
        end
        dram_en_rd     = run & sel_rd;
        dram_en_wr     = run & sel_wr;
        eng_dram_valid = run ? (grant_oh & {NUM_ENG{dram_valid}}) : '0;
    end

    assign eng_enable = enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cur_step   = step_q;

endmodule
